tblock_distributor: RTL and testbench

TBLOCK_DISTRIBUTOR -- requirements
Module: tblock_distributor

---
 rtl/bgpu_pkg.sv | 28 ++
 rtl/tblock_done_buffer.sv | 49 ++++
 rtl/tblock_distributor.sv | 221 ++++++++++++++++++++++
 tb/tb_tblock_distributor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bgpu_pkg.sv
// -----------------------------------------------------------------------------
// bgpu_pkg
// Shared types for the thread-block distribution path: program counter,
// data/parameter address, thread-block size/index and thread-group id. Also
// holds the modular-increment helper used by the round-robin searches.
// -----------------------------------------------------------------------------
package bgpu_pkg;

  localparam int unsigned DefaultPcWidth        = 32'd16;
  localparam int unsigned DefaultAddressWidth   = 32'd32;
  localparam int unsigned DefaultTblockIdxBits  = 32'd8;
  localparam int unsigned DefaultTblockSizeBits = 32'd4;
  localparam int unsigned DefaultTgroupIdBits   = 32'd8;

  typedef logic [DefaultPcWidth-1:0]        pc_t;
  typedef logic [DefaultAddressWidth-1:0]   addr_t;
  typedef logic [DefaultTblockIdxBits-1:0]  tblock_idx_t;
  typedef logic [DefaultTblockSizeBits-1:0] tblock_size_t;
  typedef logic [DefaultTgroupIdBits-1:0]   tgroup_id_t;

  // (base + off) mod n, used to walk the clusters from a round-robin pointer.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/tblock_done_buffer.sv
// -----------------------------------------------------------------------------
// tblock_done_buffer
// One-entry hold register for a cluster's thread-block-done report.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   done_i         done valid from the cluster
//   done_id_i      thread-group id of the finished block
//   clear_i        entry has been forwarded downstream; free it
//   ready_o        entry is empty (ready towards the cluster)
//   valid_o, id_o  held entry
// -----------------------------------------------------------------------------
module tblock_done_buffer
  import bgpu_pkg::*;
#(
  parameter int unsigned IdBits = DefaultTgroupIdBits
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              done_i,
  input  logic [IdBits-1:0] done_id_i,
  input  logic              clear_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [IdBits-1:0] id_o
);

  logic              valid_r;
  logic [IdBits-1:0] id_r;

  // Hold register: clear wins; a capture is only possible while empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= 1'b0;
      id_r    <= {IdBits{1'b0}};
    end else if (clear_i) begin
      valid_r <= 1'b0;
    end else if (done_i && !valid_r) begin
      valid_r <= 1'b1;
      id_r    <= done_id_i;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign ready_o = ~valid_r;
  assign valid_o = valid_r;
  assign id_o    = id_r;

endmodule

// File: rtl/tblock_distributor.sv
// -----------------------------------------------------------------------------
// tblock_distributor
// Spreads warp allocations from the dispatcher over NumClusters compute
// clusters (round robin over clusters with a free warp) and merges the
// per-cluster thread-block-done reports into one stream (round robin).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   warp_free_o                  some cluster has a free warp
//   allocate_warp_i + payload    allocation request from the dispatcher
//   warp_free_i                  per-cluster free-warp flags
//   allocate_warp_o + payload    one-hot allocate strobe, broadcast payload
//   tblock_done_i/_id_i/_ready_o per-cluster done streams
//   tblock_done_o/_id_o/_ready_i merged done stream to the thread engine
//   busy_o                       some block is still outstanding
// -----------------------------------------------------------------------------
module tblock_distributor
  import bgpu_pkg::*;
#(
  parameter int unsigned NumClusters    = 32'd4,
  parameter int unsigned PcWidth        = DefaultPcWidth,
  parameter int unsigned AddressWidth   = DefaultAddressWidth,
  parameter int unsigned TblockIdxBits  = DefaultTblockIdxBits,
  parameter int unsigned TblockSizeBits = DefaultTblockSizeBits,
  parameter int unsigned TgroupIdBits   = DefaultTgroupIdBits
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  output logic                                warp_free_o,
  input  logic                                allocate_warp_i,
  input  logic [PcWidth-1:0]                  allocate_pc_i,
  input  logic [AddressWidth-1:0]             allocate_dp_addr_i,
  input  logic [TblockSizeBits-1:0]           allocate_tblock_size_i,
  input  logic [TblockIdxBits-1:0]            allocate_tblock_idx_i,
  input  logic [TgroupIdBits-1:0]             allocate_tgroup_id_i,
  input  logic [NumClusters-1:0]              warp_free_i,
  output logic [NumClusters-1:0]              allocate_warp_o,
  output logic [PcWidth-1:0]                  allocate_pc_o,
  output logic [AddressWidth-1:0]             allocate_dp_addr_o,
  output logic [TblockSizeBits-1:0]           allocate_tblock_size_o,
  output logic [TblockIdxBits-1:0]            allocate_tblock_idx_o,
  output logic [TgroupIdBits-1:0]             allocate_tgroup_id_o,
  input  logic [NumClusters-1:0]              tblock_done_i,
  input  logic [NumClusters*TgroupIdBits-1:0] tblock_done_id_i,
  output logic [NumClusters-1:0]              tblock_done_ready_o,
  output logic                                tblock_done_o,
  output logic [TgroupIdBits-1:0]             tblock_done_id_o,
  input  logic                                tblock_done_ready_i,
  output logic                                busy_o
);

  localparam int unsigned PtrW = $clog2(NumClusters);
  localparam int unsigned CntW = TblockIdxBits + 32'd1;
  localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
  localparam logic [CntW-1:0] CntOne  = CntW'(1'b1);

  logic [PtrW-1:0]         rr_alloc_r;
  logic [PtrW-1:0]         rr_done_r;
  logic                    locked_r;
  logic [PtrW-1:0]         locked_idx_r;
  logic [CntW-1:0]         cnt_r [NumClusters];

  logic                    alloc_hit_s;
  logic [PtrW-1:0]         alloc_sel_s;
  logic [PtrW-1:0]         alloc_cand_s;
  logic [NumClusters-1:0]  alloc_vec_s;
  logic                    done_any_s;
  logic [PtrW-1:0]         done_win_s;
  logic [PtrW-1:0]         done_cand_s;
  logic                    done_fire_s;
  logic [NumClusters-1:0]  hold_valid_s;
  logic [NumClusters-1:0]  hold_clear_s;
  logic [NumClusters-1:0]  ready_s;
  logic [NumClusters-1:0]  done_cap_s;
  logic [TgroupIdBits-1:0] hold_id_s [NumClusters];
  logic                    cnt_nz_s;

  assign warp_free_o            = |warp_free_i;
  assign allocate_pc_o          = allocate_pc_i;
  assign allocate_dp_addr_o     = allocate_dp_addr_i;
  assign allocate_tblock_size_o = allocate_tblock_size_i;
  assign allocate_tblock_idx_o  = allocate_tblock_idx_i;
  assign allocate_tgroup_id_o   = allocate_tgroup_id_i;

  // Allocation search: first free cluster at or after rr_alloc_r, with wrap.
  always_comb begin
    alloc_hit_s  = 1'b0;
    alloc_sel_s  = {PtrW{1'b0}};
    alloc_cand_s = {PtrW{1'b0}};
    for (int unsigned i = 32'd0; i < NumClusters; i++) begin
      alloc_cand_s = PtrW'(rr_wrap(32'(rr_alloc_r), i, NumClusters));
      if (!alloc_hit_s && warp_free_i[alloc_cand_s]) begin
        alloc_hit_s = 1'b1;
        alloc_sel_s = alloc_cand_s;
      end else begin
        alloc_hit_s = alloc_hit_s;
      end
    end
  end

  // One-hot strobe; a request with no free warp is dropped.
  always_comb begin
    alloc_vec_s = {NumClusters{1'b0}};
    if (allocate_warp_i && alloc_hit_s) begin
      alloc_vec_s[alloc_sel_s] = 1'b1;
    end else begin
      alloc_vec_s = {NumClusters{1'b0}};
    end
  end

  assign allocate_warp_o = alloc_vec_s;

  // Done search; a winner offered but not yet accepted stays locked so the
  // output cannot switch to a slot that captures later at higher priority.
  always_comb begin
    done_any_s  = |hold_valid_s;
    done_win_s  = {PtrW{1'b0}};
    done_cand_s = {PtrW{1'b0}};
    if (locked_r) begin
      done_win_s = locked_idx_r;
    end else begin
      for (int unsigned i = 32'd0; i < NumClusters; i++) begin
        done_cand_s = PtrW'(rr_wrap(32'(rr_done_r), 32'(NumClusters - 32'd1 - i), NumClusters));
        if (hold_valid_s[done_cand_s]) begin
          done_win_s = done_cand_s;
        end else begin
          done_win_s = done_win_s;
        end
      end
    end
  end

  assign done_fire_s      = done_any_s && tblock_done_ready_i;
  assign tblock_done_o    = done_any_s;
  assign tblock_done_id_o = hold_id_s[done_win_s];

  // Clear strobe for the accepted winner.
  always_comb begin
    hold_clear_s = {NumClusters{1'b0}};
    if (done_fire_s) begin
      hold_clear_s[done_win_s] = 1'b1;
    end else begin
      hold_clear_s = {NumClusters{1'b0}};
    end
  end

  assign done_cap_s          = tblock_done_i & ready_s;
  assign tblock_done_ready_o = ready_s;

  for (genvar c = 0; c < NumClusters; c++) begin : g_hold
    tblock_done_buffer #(
      .IdBits (TgroupIdBits)
    ) u_hold (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .done_i    (tblock_done_i[c]),
      .done_id_i (tblock_done_id_i[c*TgroupIdBits +: TgroupIdBits]),
      .clear_i   (hold_clear_s[c]),
      .ready_o   (ready_s[c]),
      .valid_o   (hold_valid_s[c]),
      .id_o      (hold_id_s[c])
    );
  end

  // Round-robin pointers and the done-winner lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_alloc_r   <= {PtrW{1'b0}};
      rr_done_r    <= {PtrW{1'b0}};
      locked_r     <= 1'b0;
      locked_idx_r <= {PtrW{1'b0}};
    end else begin
      if (allocate_warp_i && alloc_hit_s) begin
        rr_alloc_r <= PtrW'(rr_wrap(32'(alloc_sel_s), 32'd1, NumClusters));
      end
      if (done_fire_s) begin
        rr_done_r <= PtrW'(rr_wrap(32'(done_win_s), 32'd1, NumClusters));
      end
      locked_r     <= done_any_s && !tblock_done_ready_i;
      locked_idx_r <= done_win_s;
    end
  end

  // Outstanding-block counters: +1 per allocation, -1 per captured done,
  // saturating at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < int'(NumClusters); c++) begin
        cnt_r[c] <= CntZero;
      end
    end else begin
      for (int c = 0; c < int'(NumClusters); c++) begin
        case ({alloc_vec_s[c], done_cap_s[c]})
          2'b10: cnt_r[c] <= cnt_r[c] + CntOne;
          2'b01: begin
            if (cnt_r[c] != CntZero) begin
              cnt_r[c] <= cnt_r[c] - CntOne;
            end else begin
              cnt_r[c] <= CntZero;
            end
          end
          default: cnt_r[c] <= cnt_r[c];
        endcase
      end
    end
  end

  // Busy while any counter is non-zero or any done is still held.
  always_comb begin
    cnt_nz_s = 1'b0;
    for (int c = 0; c < int'(NumClusters); c++) begin
      if (cnt_r[c] != CntZero) begin
        cnt_nz_s = 1'b1;
      end else begin
        cnt_nz_s = cnt_nz_s;
      end
    end
  end

  assign busy_o = cnt_nz_s | (|hold_valid_s);

endmodule

// File: tb/tb_tblock_distributor.sv
// -----------------------------------------------------------------------------
// tb_tblock_distributor
// Self-checking bench for tblock_distributor (NumClusters = 4). Expected
// allocate strobes and done ids go into scoreboard queues when stimulus is
// driven and are popped when the DUT presents the matching output.
// -----------------------------------------------------------------------------
module tb_tblock_distributor;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        warp_free_o;
  logic        allocate_warp_i;
  logic [15:0] allocate_pc_i;
  logic [31:0] allocate_dp_addr_i;
  logic [3:0]  allocate_tblock_size_i;
  logic [7:0]  allocate_tblock_idx_i;
  logic [7:0]  allocate_tgroup_id_i;
  logic [3:0]  warp_free_i;
  logic [3:0]  allocate_warp_o;
  logic [15:0] allocate_pc_o;
  logic [31:0] allocate_dp_addr_o;
  logic [3:0]  allocate_tblock_size_o;
  logic [7:0]  allocate_tblock_idx_o;
  logic [7:0]  allocate_tgroup_id_o;
  logic [3:0]  tblock_done_i;
  logic [31:0] tblock_done_id_i;
  logic [3:0]  tblock_done_ready_o;
  logic        tblock_done_o;
  logic [7:0]  tblock_done_id_o;
  logic        tblock_done_ready_i;
  logic        busy_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          used;
  logic [31:0] alloc_q[$];
  logic [31:0] done_q[$];

  tblock_distributor dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .warp_free_o            (warp_free_o),
    .allocate_warp_i        (allocate_warp_i),
    .allocate_pc_i          (allocate_pc_i),
    .allocate_dp_addr_i     (allocate_dp_addr_i),
    .allocate_tblock_size_i (allocate_tblock_size_i),
    .allocate_tblock_idx_i  (allocate_tblock_idx_i),
    .allocate_tgroup_id_i   (allocate_tgroup_id_i),
    .warp_free_i            (warp_free_i),
    .allocate_warp_o        (allocate_warp_o),
    .allocate_pc_o          (allocate_pc_o),
    .allocate_dp_addr_o     (allocate_dp_addr_o),
    .allocate_tblock_size_o (allocate_tblock_size_o),
    .allocate_tblock_idx_o  (allocate_tblock_idx_o),
    .allocate_tgroup_id_o   (allocate_tgroup_id_o),
    .tblock_done_i          (tblock_done_i),
    .tblock_done_id_i       (tblock_done_id_i),
    .tblock_done_ready_o    (tblock_done_ready_o),
    .tblock_done_o          (tblock_done_o),
    .tblock_done_id_o       (tblock_done_id_o),
    .tblock_done_ready_i    (tblock_done_ready_i),
    .busy_o                 (busy_o)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // One allocation cycle with random payload; strobe checked mid-cycle.
  task automatic do_alloc(input logic [3:0] free, input logic [3:0] exp);
    logic [31:0] e;
    logic [15:0] pc;
    logic [31:0] addr;
    logic [7:0]  gid;
    pc   = 16'($urandom);
    addr = $urandom;
    gid  = 8'($urandom);
    warp_free_i            = free;
    allocate_warp_i        = 1'b1;
    allocate_pc_i          = pc;
    allocate_dp_addr_i     = addr;
    allocate_tgroup_id_i   = gid;
    allocate_tblock_size_i = 4'($urandom);
    allocate_tblock_idx_i  = 8'($urandom);
    alloc_q.push_back({28'd0, exp});
    @(negedge clk);
    e = alloc_q.pop_front();
    check_eq("alloc_onehot", {28'd0, allocate_warp_o}, e);
    check_eq("pc_pass", {16'd0, allocate_pc_o}, {16'd0, pc});
    check_eq("addr_pass", allocate_dp_addr_o, addr);
    check_eq("gid_pass", {24'd0, allocate_tgroup_id_o}, {24'd0, gid});
    tick();
    allocate_warp_i = 1'b0;
  endtask

  // Present done reports for one cycle.
  task automatic drive_done(input logic [3:0] mask, input logic [31:0] ids);
    tblock_done_i    = mask;
    tblock_done_id_i = ids;
    tick();
    tblock_done_i    = 4'd0;
  endtask

  // Pop the done scoreboard as the merged stream fires; bounded.
  task automatic drain_done(input int budget, output int cycles);
    logic [31:0] e;
    cycles = 0;
    while (done_q.size() != 0 && cycles < budget) begin
      @(negedge clk);
      if (tblock_done_o && tblock_done_ready_i) begin
        e = done_q.pop_front();
        check_eq("done_id", {24'd0, tblock_done_id_o}, e);
      end
      cycles++;
      tick();
    end
    if (done_q.size() != 0) begin
      check_eq("done_timeout", 32'(done_q.size()), 32'd0);
      done_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; allocate_warp_i = 1'b0; allocate_pc_i = 16'd0;
    allocate_dp_addr_i = 32'd0; allocate_tblock_size_i = 4'd0;
    allocate_tblock_idx_i = 8'd0; allocate_tgroup_id_i = 8'd0;
    warp_free_i = 4'd0; tblock_done_i = 4'd0; tblock_done_id_i = 32'd0;
    tblock_done_ready_i = 1'b1;
    do_reset();

    // Reset state
    warp_free_i = 4'b0101;
    @(negedge clk);
    check_eq("rst_done", {31'd0, tblock_done_o}, 32'd0);
    check_eq("rst_ready", {28'd0, tblock_done_ready_o}, 32'hf);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_alloc", {28'd0, allocate_warp_o}, 32'd0);
    check_eq("rst_free", {31'd0, warp_free_o}, 32'd1);
    tick();

    // Back-to-back allocations with every cluster free
    do_alloc(4'b1111, 4'b0001);
    do_alloc(4'b1111, 4'b0010);
    do_alloc(4'b1111, 4'b0100);
    do_alloc(4'b1111, 4'b1000);
    do_alloc(4'b1111, 4'b0001);
    @(negedge clk);
    check_eq("busy_after_alloc", {31'd0, busy_o}, 32'd1);
    tick();

    // Sparse free mask from pointer 0; pointer moves to 3
    do_reset();
    @(negedge clk);
    check_eq("busy_cleared", {31'd0, busy_o}, 32'd0);
    tick();
    do_alloc(4'b0100, 4'b0100);
    do_alloc(4'b1111, 4'b1000);
    do_alloc(4'b1001, 4'b0001);

    // Request with nothing free is dropped without moving the pointer
    warp_free_i = 4'b0000;
    allocate_warp_i = 1'b1;
    @(negedge clk);
    $display("note: protocol error injected (allocate with no free warp)");
    check_eq("nofree_flag", {31'd0, warp_free_o}, 32'd0);
    check_eq("nofree_alloc", {28'd0, allocate_warp_o}, 32'd0);
    tick();
    allocate_warp_i = 1'b0;
    do_alloc(4'b1111, 4'b0010);

    // Two dones in one cycle drain on consecutive cycles
    do_reset();
    do_alloc(4'b0101, 4'b0001);
    do_alloc(4'b0101, 4'b0100);
    tblock_done_ready_i = 1'b1;
    drive_done(4'b0101, {8'd0, 8'd9, 8'd0, 8'd7});
    done_q.push_back(32'd7);
    done_q.push_back(32'd9);
    drain_done(10, used);
    check_eq("drain_cycles", 32'(used), 32'd2);
    @(negedge clk);
    check_eq("drained_done", {31'd0, tblock_done_o}, 32'd0);
    check_eq("drained_busy", {31'd0, busy_o}, 32'd0);
    tick();

    // Backpressure: output held stable, then accepted exactly once
    do_alloc(4'b0010, 4'b0010);
    tblock_done_ready_i = 1'b0;
    drive_done(4'b0010, {8'd0, 8'd0, 8'h33, 8'd0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_ready1", {31'd0, tblock_done_ready_o[1]}, 32'd0);
      check_eq("bp_done", {31'd0, tblock_done_o}, 32'd1);
      check_eq("bp_id", {24'd0, tblock_done_id_o}, 32'h33);
      tick();
    end
    done_q.push_back(32'h33);
    tblock_done_ready_i = 1'b1;
    drain_done(10, used);
    check_eq("bp_accept_cycles", 32'(used), 32'd1);
    @(negedge clk);
    check_eq("bp_after_done", {31'd0, tblock_done_o}, 32'd0);
    check_eq("bp_after_ready", {28'd0, tblock_done_ready_o}, 32'hf);
    check_eq("bp_after_busy", {31'd0, busy_o}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("bp_once", {31'd0, tblock_done_o}, 32'd0);
    tick();

    // Reset with three entries held discards them
    do_alloc(4'b0111, 4'b0100);
    do_alloc(4'b0111, 4'b0001);
    do_alloc(4'b0111, 4'b0010);
    tblock_done_ready_i = 1'b0;
    drive_done(4'b0111, {8'd0, 8'd3, 8'd2, 8'd1});
    @(negedge clk);
    check_eq("held_ready", {28'd0, tblock_done_ready_o}, 32'h8);
    check_eq("held_busy", {31'd0, busy_o}, 32'd1);
    check_eq("held_done", {31'd0, tblock_done_o}, 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_done", {31'd0, tblock_done_o}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("mid_rst_ready", {28'd0, tblock_done_ready_o}, 32'hf);
    tblock_done_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check_eq("mid_rst_no_out", {31'd0, tblock_done_o}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
